// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART FSM encodings, prescaler default and sample-point constants
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      PARITY  = 3'd3,
      STOPBIT = 3'd4
   } uart_state_e;

   localparam int UART_PRESC_LEN = 4;

   // Mid-bit samples at 7/8/9 of a 16-count bit; the bit ends on count 15
   localparam int SAMPLE_EARLY  = 7;
   localparam int SAMPLE_MID    = 8;
   localparam int SAMPLE_DECIDE = 9;
   localparam int BIT_END       = 15;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx pin synchronizer with falling-edge detect
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic rx_pin_i,
   output logic rxs_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rxs_prev_q, rxs_prev_d;
   logic [SYNC_STAGES:0]   fill_q, fill_d;

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], rx_pin_i};
      rxs_prev_d = sync_q[SYNC_STAGES-1];
      fill_d     = {fill_q[SYNC_STAGES-1:0], 1'b1};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_q     <= '1;
         rxs_prev_q <= 1'b1;
         fill_q     <= '0;
      end else begin
         sync_q     <= sync_d;
         rxs_prev_q <= rxs_prev_d;
         fill_q     <= fill_d;
      end
   end

   assign rxs_o = sync_q[SYNC_STAGES-1];

   // Edges are masked until real pin samples have replaced the reset ones,
   // so a line held low through reset exit never looks like a start bit.
   assign fall_o = fill_q[SYNC_STAGES] & rxs_prev_q & ~rxs_o;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver, 8N1/8E1/8O1
// Optional break detection is built when UART_RX_BREAK_DET_EN is defined.
module uart_rx
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int PRESC_LEN   = UART_PRESC_LEN
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       uart_cken_i,
   input  logic       parity_type_i,
   input  logic       parity_en_i,
   input  logic       rx_pin_i,
   output logic [7:0] rx_byte_o,
   output logic       rx_valid_o,
   output logic       parity_err_o,
   output logic       frame_err_o,
   output logic       rx_busy_o,
   output logic       rx_break_o
);

   localparam logic [PRESC_LEN-1:0] CNT_EARLY  = PRESC_LEN'(SAMPLE_EARLY);
   localparam logic [PRESC_LEN-1:0] CNT_MID    = PRESC_LEN'(SAMPLE_MID);
   localparam logic [PRESC_LEN-1:0] CNT_DECIDE = PRESC_LEN'(SAMPLE_DECIDE);
   localparam logic [PRESC_LEN-1:0] CNT_END    = PRESC_LEN'(BIT_END);

   logic rxs, fall;

   uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .resetn   (resetn),
      .rx_pin_i (rx_pin_i),
      .rxs_o    (rxs),
      .fall_o   (fall)
   );

   uart_state_e          state_q, state_d;
   logic [PRESC_LEN-1:0] presc_q, presc_d;
   logic                 s7_q, s7_d, s8_q, s8_d;
   logic [7:0]           shift_q, shift_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic                 acc_q, acc_d;
   logic                 perr_q, perr_d;
   logic                 par_en_q, par_en_d;
   logic [7:0]           rx_byte_q, rx_byte_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_BREAK_DET_EN
   logic                 par_zero_q, par_zero_d;
   logic                 break_wait_q, break_wait_d;
   logic                 rx_break_q, rx_break_d;
`endif

   logic at_early, at_mid, decide, baud_tick, sample;

   assign at_early  = uart_cken_i && (presc_q == CNT_EARLY);
   assign at_mid    = uart_cken_i && (presc_q == CNT_MID);
   assign decide    = uart_cken_i && (presc_q == CNT_DECIDE);
   assign baud_tick = uart_cken_i && (presc_q == CNT_END);
   assign sample    = majority3(s7_q, s8_q, rxs);

   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      s7_d         = s7_q;
      s8_d         = s8_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      acc_d        = acc_q;
      perr_d       = perr_q;
      par_en_d     = par_en_q;
      rx_byte_d    = rx_byte_q;
      rx_valid_d   = 1'b0;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
`ifdef UART_RX_BREAK_DET_EN
      par_zero_d   = par_zero_q;
      break_wait_d = break_wait_q;
      rx_break_d   = 1'b0;
`endif

      if (uart_cken_i) presc_d = presc_q + 1'b1;
      if (at_early)    s7_d    = rxs;
      if (at_mid)      s8_d    = rxs;

      unique case (state_q)
         IDLE: begin
`ifdef UART_RX_BREAK_DET_EN
            if (break_wait_q) begin
               if (rxs) break_wait_d = 1'b0;
            end else
`endif
            if (fall) begin
               state_d = START;
               presc_d = '0;
            end
         end

         START: begin
            if (decide) begin
               if (sample) begin
                  state_d = IDLE;
               end else begin
                  par_en_d  = parity_en_i;
                  acc_d     = parity_type_i;
                  perr_d    = 1'b0;
                  bit_cnt_d = '0;
               end
            end
            if (baud_tick) state_d = DATA;
         end

         DATA: begin
            if (decide) begin
               shift_d = {sample, shift_q[7:1]};
               acc_d   = acc_q ^ sample;
            end
            if (baud_tick) begin
               if (bit_cnt_q == 3'd7) state_d = par_en_q ? PARITY : STOPBIT;
               else                   bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end

         PARITY: begin
            if (decide) begin
               perr_d = sample ^ acc_q;
`ifdef UART_RX_BREAK_DET_EN
               par_zero_d = ~sample;
`endif
            end
            if (baud_tick) state_d = STOPBIT;
         end

         STOPBIT: begin
            // Leave mid stop bit so a back-to-back start edge is caught early
            if (decide) begin
               rx_valid_d   = 1'b1;
               rx_byte_d    = shift_q;
               parity_err_d = perr_q & par_en_q;
               frame_err_d  = ~sample;
               state_d      = IDLE;
`ifdef UART_RX_BREAK_DET_EN
               if ((shift_q == 8'h00) && (!par_en_q || par_zero_q) && !sample) begin
                  rx_break_d   = 1'b1;
                  break_wait_d = 1'b1;
               end
`endif
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         presc_q      <= '0;
         s7_q         <= 1'b1;
         s8_q         <= 1'b1;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         acc_q        <= 1'b0;
         perr_q       <= 1'b0;
         par_en_q     <= 1'b0;
         rx_byte_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         par_zero_q   <= 1'b0;
         break_wait_q <= 1'b0;
         rx_break_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         s7_q         <= s7_d;
         s8_q         <= s8_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         acc_q        <= acc_d;
         perr_q       <= perr_d;
         par_en_q     <= par_en_d;
         rx_byte_q    <= rx_byte_d;
         rx_valid_q   <= rx_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
`ifdef UART_RX_BREAK_DET_EN
         par_zero_q   <= par_zero_d;
         break_wait_q <= break_wait_d;
         rx_break_q   <= rx_break_d;
`endif
      end
   end

   assign rx_byte_o    = rx_byte_q;
   assign rx_valid_o   = rx_valid_q;
   assign parity_err_o = parity_err_q;
   assign frame_err_o  = frame_err_q;
   assign rx_busy_o    = (state_q != IDLE);
`ifdef UART_RX_BREAK_DET_EN
   assign rx_break_o   = rx_break_q;
`else
   assign rx_break_o   = 1'b0;
`endif

endmodule
